seg_bcd_conv: RTL

Iterative binary-to-BCD converter between the distance measurement logic and `seg_drive`. It accepts a binary distance value with a valid strobe and runs a shift-and-add-3 (double dabble) conversion, one bit per clock. It then presents a packed 6-digit BCD word with a one-cycle `data_vld` pulse, ready for direct connection to `seg_drive`'s `display_data`/`data_vld`. An overflow flag and a busy flag are provided for the upstream producer.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_bcd_adj.sv | 16 +
 rtl/seg_bcd_conv.sv | 101 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display path (seg_bcd_conv, seg_drive).
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } seg_state_e;

    localparam int unsigned SEG_DIGITS  = 6;
    localparam int unsigned SEG_MAX_VAL = 999999;

    typedef logic [3:0] seg_bcd_t;

    function automatic longint unsigned seg_pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_bcd_adj.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets +3 ahead of the next left shift.
module seg_bcd_adj
    import seg_pkg::*;
(
    input  seg_bcd_t nib_i,
    output seg_bcd_t nib_o
);

    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end

endmodule

// File: rtl/seg_bcd_conv.sv
// Iterative binary-to-BCD converter, one input bit per clock, feeding seg_drive.
// Optional macro SEG_BCD_SAT_EN: clamp out-of-range inputs to all nines instead of wrapping.
module seg_bcd_conv
    import seg_pkg::*;
#(
    parameter int unsigned DIN_W  = 20,
    parameter int unsigned DIGITS = SEG_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_W-1:0]      din,
    input  logic                  din_vld,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   display_data,
    output logic                  data_vld,
    output logic                  ovf
);

    localparam int unsigned ACC_W = 4 * (DIGITS + 1);
    localparam int unsigned OUT_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIN_W - 1);
    localparam logic [63:0]      MAX_VAL  = 64'(seg_pow10(DIGITS) - 1);

    seg_state_e          state_q;
    logic [DIN_W-1:0]    bin_q;
    logic [ACC_W-1:0]    bcd_q;
    logic [ACC_W-1:0]    bcd_adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_pend_q;
    logic [OUT_W-1:0]    display_q;
    logic                data_vld_q;
    logic                ovf_q;

    logic                ovf_d;
    logic [DIN_W-1:0]    bin_d;

    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
        seg_bcd_adj u_adj (
            .nib_i (bcd_q[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        ovf_d = (64'(din) > MAX_VAL);
`ifdef SEG_BCD_SAT_EN
        bin_d = ovf_d ? MAX_VAL[DIN_W-1:0] : din;
`else
        bin_d = din;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            display_q  <= '0;
            data_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            data_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (din_vld) begin
                        bin_q      <= bin_d;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        ovf_pend_q <= ovf_d;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    // adjust-then-shift of the concatenated {bcd, bin} register
                    bcd_q <= {bcd_adj[ACC_W-2:0], bin_q[DIN_W-1]};
                    bin_q <= {bin_q[DIN_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    display_q  <= bcd_q[OUT_W-1:0];
                    ovf_q      <= ovf_pend_q;
                    data_vld_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign display_data = display_q;
    assign data_vld     = data_vld_q;
    assign ovf          = ovf_q;

endmodule
